// File: rtl/tuner_lock_phy.sv
// rtl/tuner_lock_phy.sv - per-ring peak lock and three-point dither tracking stage
//
// Purpose:
//   Accepts one peak list from the tuner search stage, drives the ring tune
//   code to the selected peak, then tracks resonance with a three-point
//   dither (c, c-step, c+step). It steps the centre toward the highest
//   drop-port power. Lock is declared after LockCount consecutive stay
//   decisions.
//
// Ports:
//   i_clk, i_rst_n                     clock, synchronous active-low reset
//   i_peaks_val / o_peaks_rdy          peak list handshake
//   i_ring_tune_peaks, i_pwr_peaks     peak tune codes and peak powers
//   i_peaks_cnt, i_target_idx          valid entries, entry to lock to
//   i_clear                            abandon lock, return to IDLE
//   i_pwr_val / o_pwr_rdy, i_pwr_data  power-detect handshake and sample
//   o_ring_tune, o_ring_tune_val /
//     i_ring_tune_rdy                  tune write handshake
//   o_lock, o_lock_err, o_lock_pwr     lock status, invalid target, centre power
//   o_mon_state                        state encoding
//   o_mon_drift                        centre minus captured peak (optional)
//
// Optional feature macro: TUNER_LOCK_DRIFT_MON_EN
//   Adds o_mon_drift and parameter DriftLimit. If the centre wanders more
//   than DriftLimit codes from the captured peak, the block enters ERR.

module tuner_lock_phy #(
  parameter int DAC_WIDTH    = 8,
  parameter int ADC_WIDTH    = 8,
  parameter int NUM_TARGET   = 4,
  parameter int DitherStep   = 1,
  parameter int SettleCycles = 4,
  parameter int LockCount    = 3
`ifdef TUNER_LOCK_DRIFT_MON_EN
  ,
  parameter int DriftLimit   = 8
`endif
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_peaks_val,
  output logic                          o_peaks_rdy,
  input  logic [DAC_WIDTH-1:0]          i_ring_tune_peaks [NUM_TARGET],
  input  logic [ADC_WIDTH-1:0]          i_pwr_peaks [NUM_TARGET],
  input  logic [$clog2(NUM_TARGET):0]   i_peaks_cnt,
  input  logic [$clog2(NUM_TARGET)-1:0] i_target_idx,
  input  logic                          i_clear,
  input  logic                          i_pwr_val,
  output logic                          o_pwr_rdy,
  input  logic [ADC_WIDTH-1:0]          i_pwr_data,
  output logic [DAC_WIDTH-1:0]          o_ring_tune,
  output logic                          o_ring_tune_val,
  input  logic                          i_ring_tune_rdy,
  output logic                          o_lock,
  output logic                          o_lock_err,
  output logic [ADC_WIDTH-1:0]          o_lock_pwr,
`ifdef TUNER_LOCK_DRIFT_MON_EN
  output logic signed [DAC_WIDTH:0]     o_mon_drift,
`endif
  output logic [2:0]                    o_mon_state
);

  localparam int IW  = $clog2(NUM_TARGET);
  localparam int SCW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam int LCW = $clog2(LockCount + 1);
  localparam logic [DAC_WIDTH-1:0] STEP     = DAC_WIDTH'(DitherStep);
  localparam logic [DAC_WIDTH-1:0] CODE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WRITE  = 3'd2,
    S_SETTLE = 3'd3,
    S_MEAS   = 3'd4,
    S_DECIDE = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PH_CTR = 2'd0,
    PH_DN  = 2'd1,
    PH_UP  = 2'd2
  } phase_t;

  state_t               r_state;
  phase_t               r_phase;
  logic [DAC_WIDTH-1:0] r_peaks [NUM_TARGET];
  logic [ADC_WIDTH-1:0] r_pwr_peaks [NUM_TARGET];
  logic [IW:0]          r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DAC_WIDTH-1:0] r_c;
  logic [ADC_WIDTH-1:0] r_p_ctr;
  logic [ADC_WIDTH-1:0] r_p_dn;
  logic [ADC_WIDTH-1:0] r_p_up;
  logic [SCW-1:0]       r_settle_cnt;
  logic [LCW-1:0]       r_stay_cnt;
  logic                 r_peaks_rdy;
  logic [DAC_WIDTH-1:0] r_ring_tune;
  logic                 r_tune_val;
  logic                 r_pwr_rdy;
  logic                 r_lock;
  logic                 r_lock_err;
  logic [ADC_WIDTH-1:0] r_lock_pwr;

  logic [DAC_WIDTH-1:0] w_code_dn;
  logic [DAC_WIDTH-1:0] w_code_up;
  logic [DAC_WIDTH-1:0] w_next_c;
  logic [DAC_WIDTH-1:0] w_peak_sel;
  logic [LCW-1:0]       w_stay_inc;
  logic                 w_move_up;
  logic                 w_move_dn;
  logic                 w_moved;
  logic                 w_idx_bad;
  logic                 w_drift_over;

  // Dither neighbours saturate at the code range ends
  assign w_code_dn = (r_c >= STEP) ? (r_c - STEP) : '0;
  assign w_code_up = (r_c <= (CODE_MAX - STEP)) ? (r_c + STEP) : CODE_MAX;

  // Up wins ties against down; both must strictly beat the centre
  assign w_move_up = (r_p_up > r_p_ctr) && (r_p_up >= r_p_dn);
  assign w_move_dn = !w_move_up && (r_p_dn > r_p_ctr);
  assign w_next_c  = w_move_up ? w_code_up : (w_move_dn ? w_code_dn : r_c);
  // A move clamped at a range end leaves the code unchanged and is a stay
  assign w_moved   = (w_next_c != r_c);

  assign w_peak_sel = r_peaks[r_idx];
  assign w_idx_bad  = ({1'b0, r_idx} >= r_cnt);
  assign w_stay_inc = (r_stay_cnt == LCW'(LockCount)) ? r_stay_cnt : (r_stay_cnt + LCW'(1));

`ifdef TUNER_LOCK_DRIFT_MON_EN
  logic signed [DAC_WIDTH:0] w_drift_next;
  logic signed [DAC_WIDTH:0] w_drift_abs;

  assign w_drift_next = $signed({1'b0, w_next_c}) - $signed({1'b0, w_peak_sel});
  assign w_drift_abs  = w_drift_next[DAC_WIDTH] ? -w_drift_next : w_drift_next;
  assign w_drift_over = $unsigned(w_drift_abs) > (DAC_WIDTH+1)'(DriftLimit);
  assign o_mon_drift  = $signed({1'b0, r_c}) - $signed({1'b0, w_peak_sel});
`else
  assign w_drift_over = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_phase      <= PH_CTR;
      for (int k = 0; k < NUM_TARGET; k++) begin
        r_peaks[k]     <= '0;
        r_pwr_peaks[k] <= '0;
      end
      r_cnt        <= '0;
      r_idx        <= '0;
      r_c          <= '0;
      r_p_ctr      <= '0;
      r_p_dn       <= '0;
      r_p_up       <= '0;
      r_settle_cnt <= '0;
      r_stay_cnt   <= '0;
      r_peaks_rdy  <= 1'b0;
      r_ring_tune  <= '0;
      r_tune_val   <= 1'b0;
      r_pwr_rdy    <= 1'b0;
      r_lock       <= 1'b0;
      r_lock_err   <= 1'b0;
      r_lock_pwr   <= '0;
    end else if (i_clear) begin
      // Clear wins over any handshake completing on this edge
      r_state     <= S_IDLE;
      r_tune_val  <= 1'b0;
      r_pwr_rdy   <= 1'b0;
      r_lock      <= 1'b0;
      r_lock_err  <= 1'b0;
      r_stay_cnt  <= '0;
      r_peaks_rdy <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_ERR: begin
          r_peaks_rdy <= 1'b1;
          if (i_peaks_val && r_peaks_rdy) begin
            for (int k = 0; k < NUM_TARGET; k++) begin
              r_peaks[k]     <= i_ring_tune_peaks[k];
              r_pwr_peaks[k] <= i_pwr_peaks[k];
            end
            r_cnt       <= i_peaks_cnt;
            r_idx       <= i_target_idx;
            r_peaks_rdy <= 1'b0;
            r_lock_err  <= 1'b0;
            r_state     <= S_LOAD;
          end
        end

        S_LOAD: begin
          r_lock     <= 1'b0;
          r_stay_cnt <= '0;
          if (w_idx_bad) begin
            r_lock_err  <= 1'b1;
            r_peaks_rdy <= 1'b1;
            r_state     <= S_ERR;
          end else begin
            r_c         <= w_peak_sel;
            r_phase     <= PH_CTR;
            r_ring_tune <= w_peak_sel;
            r_tune_val  <= 1'b1;
            // Report the search-stage power of the chosen peak until the
            // first dither decision replaces it with a measured value
            r_lock_pwr  <= r_pwr_peaks[r_idx];
            r_state     <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (i_ring_tune_rdy) begin
            r_tune_val   <= 1'b0;
            r_settle_cnt <= '0;
            r_state      <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (r_settle_cnt == SCW'(SettleCycles - 1)) begin
            r_pwr_rdy <= 1'b1;
            r_state   <= S_MEAS;
          end else begin
            r_settle_cnt <= r_settle_cnt + SCW'(1);
          end
        end

        S_MEAS: begin
          if (i_pwr_val) begin
            r_pwr_rdy <= 1'b0;
            case (r_phase)
              PH_CTR: begin
                r_p_ctr     <= i_pwr_data;
                r_phase     <= PH_DN;
                r_ring_tune <= w_code_dn;
                r_tune_val  <= 1'b1;
                r_state     <= S_WRITE;
              end
              PH_DN: begin
                r_p_dn      <= i_pwr_data;
                r_phase     <= PH_UP;
                r_ring_tune <= w_code_up;
                r_tune_val  <= 1'b1;
                r_state     <= S_WRITE;
              end
              default: begin
                r_p_up  <= i_pwr_data;
                r_state <= S_DECIDE;
              end
            endcase
          end
        end

        S_DECIDE: begin
          r_lock_pwr <= r_p_ctr;
          r_c        <= w_next_c;
          r_phase    <= PH_CTR;
          if (w_moved) begin
            r_stay_cnt <= '0;
            r_lock     <= 1'b0;
          end else begin
            r_stay_cnt <= w_stay_inc;
            if (w_stay_inc == LCW'(LockCount)) begin
              r_lock <= 1'b1;
            end
          end
          if (w_drift_over) begin
            r_lock      <= 1'b0;
            r_lock_err  <= 1'b1;
            r_peaks_rdy <= 1'b1;
            r_state     <= S_ERR;
          end else begin
            r_ring_tune <= w_next_c;
            r_tune_val  <= 1'b1;
            r_state     <= S_WRITE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_peaks_rdy     = r_peaks_rdy;
  assign o_pwr_rdy       = r_pwr_rdy;
  assign o_ring_tune     = r_ring_tune;
  assign o_ring_tune_val = r_tune_val;
  assign o_lock          = r_lock;
  assign o_lock_err      = r_lock_err;
  assign o_lock_pwr      = r_lock_pwr;
  assign o_mon_state     = r_state;

endmodule

// File: tb/tb_tuner_lock_phy.sv
// tb/tb_tuner_lock_phy.sv - directed self-checking bench for tuner_lock_phy

module tb_tuner_lock_phy;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_peaks_val;
  logic       o_peaks_rdy;
  logic [7:0] peaks [4];
  logic [7:0] pwr_peaks [4];
  logic [2:0] i_peaks_cnt;
  logic [1:0] i_target_idx;
  logic       i_clear;
  logic       i_pwr_val;
  logic       o_pwr_rdy;
  logic [7:0] i_pwr_data;
  logic [7:0] o_ring_tune;
  logic       o_ring_tune_val;
  logic       i_ring_tune_rdy;
  logic       o_lock;
  logic       o_lock_err;
  logic [7:0] o_lock_pwr;
  logic [2:0] o_mon_state;
`ifdef TUNER_LOCK_DRIFT_MON_EN
  logic signed [8:0] o_mon_drift;
`endif

  int n_vec = 0;
  int n_err = 0;
  int wr_q[$];
  int last_code = 0;
  int mode = 0;
  int ppk = 0;
  bit rdy_en = 1'b1;

  tuner_lock_phy dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_peaks_val       (i_peaks_val),
    .o_peaks_rdy       (o_peaks_rdy),
    .i_ring_tune_peaks (peaks),
    .i_pwr_peaks       (pwr_peaks),
    .i_peaks_cnt       (i_peaks_cnt),
    .i_target_idx      (i_target_idx),
    .i_clear           (i_clear),
    .i_pwr_val         (i_pwr_val),
    .o_pwr_rdy         (o_pwr_rdy),
    .i_pwr_data        (i_pwr_data),
    .o_ring_tune       (o_ring_tune),
    .o_ring_tune_val   (o_ring_tune_val),
    .i_ring_tune_rdy   (i_ring_tune_rdy),
    .o_lock            (o_lock),
    .o_lock_err        (o_lock_err),
    .o_lock_pwr        (o_lock_pwr),
`ifdef TUNER_LOCK_DRIFT_MON_EN
    .o_mon_drift       (o_mon_drift),
`endif
    .o_mon_state       (o_mon_state)
  );

  always #5 clk = ~clk;

  // mode 0: flat; mode 1: peak at ppk; mode 2: rising with code
  function automatic int pmodel(input int code);
    int d;
    case (mode)
      1: begin
        d = code - ppk;
        if (d < 0) d = -d;
        return (200 - 4 * d < 0) ? 0 : 200 - 4 * d;
      end
      2: return (code > 100) ? code - 100 : 0;
      default: return 100;
    endcase
  endfunction

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input int p0, input int p1, input int p2, input int p3,
                       input int cnt, input int idx);
    peaks[0] = 8'(p0);
    peaks[1] = 8'(p1);
    peaks[2] = 8'(p2);
    peaks[3] = 8'(p3);
    i_peaks_cnt  = 3'(cnt);
    i_target_idx = 2'(idx);
    i_peaks_val  = 1'b1;
    tick();
    i_peaks_val  = 1'b0;
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    wr_q.delete();
  endtask

  task automatic wait_lock(input int budget, output int cyc);
    cyc = 0;
    while (!o_lock && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  // Environment: tune-write sink and power-detect source
  initial begin
    i_ring_tune_rdy = 1'b0;
    i_pwr_val       = 1'b0;
    i_pwr_data      = '0;
    forever begin
      @(negedge clk);
      i_ring_tune_rdy = rdy_en;
      if (o_ring_tune_val && i_ring_tune_rdy) begin
        wr_q.push_back(int'(o_ring_tune));
        last_code = int'(o_ring_tune);
      end
      i_pwr_val  = o_pwr_rdy;
      i_pwr_data = 8'(pmodel(last_code));
    end
  end

  initial begin
    int cyc;
    int ctr_exp [8];
    bit stable;
    ctr_exp = '{90, 91, 92, 93, 94, 95, 95, 95};
    rst_n = 1'b0;
    i_peaks_val = 1'b0;
    i_clear = 1'b0;
    i_peaks_cnt = '0;
    i_target_idx = '0;
    for (int k = 0; k < 4; k++) begin
      peaks[k] = '0;
      pwr_peaks[k] = '0;
    end

    // Reset
    repeat (3) @(negedge clk);
    #1;
    chk_eq("rst_state", o_mon_state, 0);
    chk_eq("rst_peaks_rdy", o_peaks_rdy, 0);
    chk_eq("rst_tune", o_ring_tune, 0);
    chk_eq("rst_tune_val", o_ring_tune_val, 0);
    chk_eq("rst_pwr_rdy", o_pwr_rdy, 0);
    chk_eq("rst_lock", o_lock, 0);
    chk_eq("rst_lock_err", o_lock_err, 0);
    chk_eq("rst_lock_pwr", o_lock_pwr, 0);
    rst_n = 1'b1;
    tick();
    chk_eq("post_rst_peaks_rdy", o_peaks_rdy, 1);

    // Load and flat-power lock at 90
    wr_q.delete();
    mode = 0;
    offer(40, 90, 150, 0, 3, 1);
    chk_eq("load_state", o_mon_state, 1);
    tick();
    chk_eq("write_state", o_mon_state, 2);
    chk_eq("first_val", o_ring_tune_val, 1);
    chk_eq("first_tune", o_ring_tune, 90);
    wait_lock(400, cyc);
    chk_eq("flat_lock", o_lock, 1);
    chk_eq("flat_lock_cycles", cyc + 1, 58);
    chk_eq("flat_lock_writes", wr_q.size(), 10);
    chk_eq("flat_w0", wr_q[0], 90);
    chk_eq("flat_w1", wr_q[1], 89);
    chk_eq("flat_w2", wr_q[2], 91);
    chk_eq("flat_tune", o_ring_tune, 90);
    chk_eq("flat_lock_pwr", o_lock_pwr, 100);

    // Tracking toward resonance at 95
    do_clear();
    chk_eq("clear_state", o_mon_state, 0);
    chk_eq("clear_lock", o_lock, 0);
    mode = 1;
    ppk = 95;
    offer(40, 90, 150, 0, 3, 1);
    wait_lock(600, cyc);
    chk_eq("trk_lock", o_lock, 1);
    chk_eq("trk_lock_writes", wr_q.size(), 25);
    chk_eq("trk_tune", o_ring_tune, 95);
    chk_eq("trk_lock_pwr", o_lock_pwr, 200);
    for (int r = 0; r < 8; r++) begin
      chk_eq($sformatf("trk_ctr%0d", r), wr_q[3 * r], ctr_exp[r]);
    end

    // Invalid target index
    do_clear();
    mode = 0;
    offer(40, 90, 150, 0, 2, 2);
    chk_eq("err_load_state", o_mon_state, 1);
    tick();
    chk_eq("err_state", o_mon_state, 6);
    chk_eq("err_flag", o_lock_err, 1);
    chk_eq("err_peaks_rdy", o_peaks_rdy, 1);
    repeat (5) tick();
    chk_eq("err_no_write", wr_q.size(), 0);

    // Recovery with a peak at code 0 (down write clamps)
    offer(0, 90, 150, 0, 3, 0);
    chk_eq("recover_err_clr", o_lock_err, 0);
    chk_eq("recover_state", o_mon_state, 1);
    cyc = 0;
    while (wr_q.size() < 3 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk_eq("zero_w0", wr_q[0], 0);
    chk_eq("zero_w1", wr_q[1], 0);
    chk_eq("zero_w2", wr_q[2], 1);

    // Peak at 255 with power rising upward: clamped up move is a stay
    do_clear();
    mode = 2;
    offer(255, 0, 0, 0, 1, 0);
    wait_lock(400, cyc);
    chk_eq("top_lock", o_lock, 1);
    chk_eq("top_lock_writes", wr_q.size(), 10);
    chk_eq("top_w0", wr_q[0], 255);
    chk_eq("top_w1", wr_q[1], 254);
    chk_eq("top_w2", wr_q[2], 255);
    chk_eq("top_tune", o_ring_tune, 255);

    // Tune write stall, settle latency, clear beats a power sample
    do_clear();
    mode = 0;
    rdy_en = 1'b0;
    offer(40, 0, 0, 0, 1, 0);
    tick();
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (o_ring_tune != 8'd40 || !o_ring_tune_val || o_mon_state != 3'd2) stable = 1'b0;
      tick();
    end
    chk_eq("stall_stable", stable, 1);
    chk_eq("stall_no_write", wr_q.size(), 0);
    rdy_en = 1'b1;
    cyc = 0;
    while (!o_pwr_rdy && cyc < 50) begin
      tick();
      cyc++;
    end
    chk_eq("settle_latency", cyc, 6);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    chk_eq("clr_pwr_state", o_mon_state, 0);
    chk_eq("clr_pwr_rdy", o_pwr_rdy, 0);
    chk_eq("clr_tune_val", o_ring_tune_val, 0);
    chk_eq("clr_peaks_rdy", o_peaks_rdy, 1);

`ifdef TUNER_LOCK_DRIFT_MON_EN
    // Peak drifting 10 codes away exceeds the drift limit of 8
    do_clear();
    mode = 1;
    ppk = 110;
    offer(100, 0, 0, 0, 1, 0);
    cyc = 0;
    while (o_mon_state != 3'd6 && cyc < 600) begin
      tick();
      cyc++;
    end
    chk_eq("drift_state", o_mon_state, 6);
    chk_eq("drift_err", o_lock_err, 1);
    chk_eq("drift_lock", o_lock, 0);
    chk_eq("drift_value", int'(o_mon_drift), 9);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
